blink_period_decoder: RTL and testbench
=======================================

// Module: blink_period_decoder
// PURPOSE
//  Receive side of the switch-selected blink scheme: watches a blink line, measures the
//  clk cycles between its toggles and decodes that interval back to the 4-bit speed index (0..15).
//  Uses the same 16-entry interval table as the blinker.
//  Sits on a board input (PMOD/loopback), driving status LEDs or a 7-seg index display.
// PARAMETERS
//  SCALE_DIV  1        table divisor; entry[i] = BASE[i]/SCALE_DIV (BASE in 100 MHz cycles)
//  TOL_SHIFT  4        match window: |period - entry[i]| <= entry[i] >> TOL_SHIFT (6.25%)
// PORTS
//  clk        in   1   system clock (100 MHz); single clock domain
//  rst_n      in   1   reset, asynchronous assert, active-low
//  blink_in   in   1   asynchronous blink line; every toggle (either edge) marks an interval end
//  idx_o      out  4   last decoded speed index
//  idx_valid  out  1   1-cycle pulse: idx_o/period_o updated this cycle
//  locked     out  1   high while successive intervals decode cleanly
//  err        out  1   1-cycle pulse: no table match, aborted search, or timeout
//  period_o   out  32  last measured interval, clk cycles
// BEHAVIOUR
//  BASE[0..15] = 12.5M,25M,50M,100M,150M,200M,300M,400M,600M,800M,1000M,1200M,1500M,2000M,2500M,3000M.
//  Reset: all outputs 0, FSM=IDLE, counter=0.
//  Input: 2-FF synchronizer + 1 edge reg; edge_det pulses 3 clk after a toggle of blink_in.
//  Counter: 32-bit, loads 1 on edge_det, else +1, saturates at 2^32-1. period = edge-to-edge cycles.
//  FSM:
//   IDLE    edge_det -> MEASURE (first edge only starts timing; no period output)
//   MEASURE edge_det -> capture period, i=0 -> SEARCH
//           counter > entry[15] + (entry[15]>>TOL_SHIFT) -> err pulse, locked<=0 -> IDLE
//   SEARCH  one entry per cycle, i=0..15; first in-window i wins (lowest index)
//           match: idx_o<=i, period_o<=period, idx_valid pulse, locked<=1 -> MEASURE
//           i=15 with no match: err pulse, locked<=0, period_o<=period -> MEASURE
//           edge_det during SEARCH: abort, err pulse, locked<=0, capture new period, restart i=0
//  Latency: match at index k -> idx_valid k+1 clk after edge_det.
//  Window arithmetic: 33-bit unsigned difference, no wrap; window = entry >> TOL_SHIFT (floor).
//  idx_valid and err never assert in the same cycle; err has priority on abort.
//  rst_n low mid-operation: immediate return to reset values, in-flight search discarded.
// CONFIGURATION
//  BLINK_DEC_CONFIRM_EN defined: a match emits idx_valid/sets locked only if its index equals
//   the previous match index; first match after IDLE, err, or reset only stores the candidate
//   (no pulse); an unequal index replaces the candidate, no err.
//  Undefined: every in-window match pulses idx_valid immediately.
// TESTING  (SCALE_DIV=100_000: entry[0]=125, entry[3]=1000, entry[15]=30000)
//  1 toggle every 1000 clk x4 -> idx_o=3, idx_valid once per interval from the 2nd edge, locked=1, period_o=1000
//  2 toggles at 125 / 30000 clk -> idx_o=0 (valid 1 clk after edge_det) / idx_o=15 (valid 16 clk after)
//  3 interval 1060 -> idx_o=3; interval 1100 -> err pulse, locked=0, period_o=1100, idx_o unchanged
//  4 locked at idx 3, then hold blink_in -> err + locked=0 at 31876 clk after last edge_det; next edge no output
//  5 two toggles 5 clk apart after a 1000 interval -> err (abort), search restarts on period 5, err again
//  6 rst_n low mid-SEARCH -> all outputs 0 asynchronously; CONFIRM_EN: 1000,1000 -> first pulse on 2nd interval only

Source files
------------

// File: rtl/blink_period_decoder.sv
// Blink-line interval decoder: times edge-to-edge periods and maps them back to a 4-bit speed index.
// Latency: idx_valid k+1 clk after edge_det for a match at index k; edge_det trails blink_in by 3 clk.
// No backpressure (pulsed outputs). Optional BLINK_DEC_CONFIRM_EN requires two equal matches before a pulse.
module blink_period_decoder #(
  parameter int unsigned SCALE_DIV = 1,
  parameter int unsigned TOL_SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blink_in,
  output logic [3:0]  idx_o,
  output logic        idx_valid,
  output logic        locked,
  output logic        err,
  output logic [31:0] period_o
);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_SEARCH} state_t;

  function automatic logic [31:0] f_base(input logic [3:0] i);
    case (i)
      4'd0:    f_base = 32'd12_500_000;
      4'd1:    f_base = 32'd25_000_000;
      4'd2:    f_base = 32'd50_000_000;
      4'd3:    f_base = 32'd100_000_000;
      4'd4:    f_base = 32'd150_000_000;
      4'd5:    f_base = 32'd200_000_000;
      4'd6:    f_base = 32'd300_000_000;
      4'd7:    f_base = 32'd400_000_000;
      4'd8:    f_base = 32'd600_000_000;
      4'd9:    f_base = 32'd800_000_000;
      4'd10:   f_base = 32'd1_000_000_000;
      4'd11:   f_base = 32'd1_200_000_000;
      4'd12:   f_base = 32'd1_500_000_000;
      4'd13:   f_base = 32'd2_000_000_000;
      4'd14:   f_base = 32'd2_500_000_000;
      default: f_base = 32'd3_000_000_000;
    endcase
  endfunction

  function automatic logic [31:0] f_entry(input logic [3:0] i);
    f_entry = f_base(i) / SCALE_DIV;
  endfunction

  localparam logic [31:0] E15      = f_entry(4'd15);
  localparam logic [32:0] TMO_LIM  = {1'b0, E15} + {1'b0, (E15 >> TOL_SHIFT)};

  logic        r_sync1, r_sync2, r_edge;
  logic [31:0] r_cnt;
  logic [31:0] r_period;
  logic [3:0]  r_i;
  state_t      r_state;
`ifdef BLINK_DEC_CONFIRM_EN
  logic [3:0]  r_cand;
  logic        r_cand_vld;
`endif

  logic        w_edge;
  logic [31:0] w_entry;
  logic [31:0] w_win;
  logic [32:0] w_diff;
  logic        w_hit;
  logic        w_timeout;

  assign w_edge    = r_sync2 ^ r_edge;
  assign w_entry   = f_entry(r_i);
  assign w_win     = w_entry >> TOL_SHIFT;
  assign w_diff    = (r_period >= w_entry) ? ({1'b0, r_period} - {1'b0, w_entry})
                                           : ({1'b0, w_entry} - {1'b0, r_period});
  assign w_hit     = (w_diff <= {1'b0, w_win});
  assign w_timeout = ({1'b0, r_cnt} > TMO_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
      r_cnt   <= 32'd0;
    end else begin
      r_sync1 <= blink_in;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
      if (w_edge)
        r_cnt <= 32'd1;
      else if (r_cnt != 32'hFFFF_FFFF)
        r_cnt <= r_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_i        <= 4'd0;
      r_period   <= 32'd0;
      idx_o      <= 4'd0;
      idx_valid  <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      period_o   <= 32'd0;
`ifdef BLINK_DEC_CONFIRM_EN
      r_cand     <= 4'd0;
      r_cand_vld <= 1'b0;
`endif
    end else begin
      idx_valid <= 1'b0;
      err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_edge)
            r_state <= S_MEASURE;
        end
        S_MEASURE: begin
          if (w_edge) begin
            r_period <= r_cnt;
            r_i      <= 4'd0;
            r_state  <= S_SEARCH;
          end else if (w_timeout) begin
            err     <= 1'b1;
            locked  <= 1'b0;
            r_state <= S_IDLE;
`ifdef BLINK_DEC_CONFIRM_EN
            r_cand_vld <= 1'b0;
`endif
          end
        end
        S_SEARCH: begin
          // A new edge beats the compare: the running search is stale.
          if (w_edge) begin
            err      <= 1'b1;
            locked   <= 1'b0;
            r_period <= r_cnt;
            r_i      <= 4'd0;
`ifdef BLINK_DEC_CONFIRM_EN
            r_cand_vld <= 1'b0;
`endif
          end else if (w_hit) begin
`ifdef BLINK_DEC_CONFIRM_EN
            if (r_cand_vld && (r_cand == r_i)) begin
              idx_o     <= r_i;
              period_o  <= r_period;
              idx_valid <= 1'b1;
              locked    <= 1'b1;
            end else begin
              r_cand     <= r_i;
              r_cand_vld <= 1'b1;
            end
`else
            idx_o     <= r_i;
            period_o  <= r_period;
            idx_valid <= 1'b1;
            locked    <= 1'b1;
`endif
            r_state <= S_MEASURE;
          end else if (r_i == 4'd15) begin
            err      <= 1'b1;
            locked   <= 1'b0;
            period_o <= r_period;
            r_state  <= S_MEASURE;
`ifdef BLINK_DEC_CONFIRM_EN
            r_cand_vld <= 1'b0;
`endif
          end else begin
            r_i <= r_i + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blink_period_decoder.sv
// Directed bench for blink_period_decoder with a scaled-down table (entry[3]=1000, entry[15]=30000).
// Latencies are counted from the blink_in toggle: edge_det takes 3 clk, a match at index k k+1 more.
`timescale 1ns/1ps
module tb_blink_period_decoder;

  logic        clk;
  logic        rst_n;
  logic        blink_in;
  logic [3:0]  idx_o;
  logic        idx_valid;
  logic        locked;
  logic        err;
  logic [31:0] period_o;

  blink_period_decoder #(.SCALE_DIV(100000), .TOL_SHIFT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blink_in  (blink_in),
    .idx_o     (idx_o),
    .idx_valid (idx_valid),
    .locked    (locked),
    .err       (err),
    .period_o  (period_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned t_tog = 0;
  int unsigned vld_cnt = 0, err_cnt = 0;
  int unsigned vld_at = 0, err_at = 0;
  bit          both = 1'b0;
  int          n_vec = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (idx_valid) begin vld_cnt++; vld_at = cyc; end
    if (err)       begin err_cnt++; err_at = cyc; end
    if (idx_valid && err) both = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Toggle blink_in n cycles after the previous toggle.
  task automatic toggle_at(input int unsigned n);
    while (cyc < t_tog + n) begin
      @(posedge clk);
      #1;
    end
    blink_in = ~blink_in;
    t_tog = cyc;
  endtask

  initial begin
    rst_n = 1'b0;
    blink_in = 1'b0;
    settle(3);
    chk("rst_idx", idx_o, 0);
    chk("rst_vld", idx_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_period", period_o, 0);
    rst_n = 1'b1;
    settle(3);
    t_tog = cyc;

    // steady 1000-cycle blinking
    toggle_at(10); settle(30);
    chk("t1_first_edge_silent", vld_cnt, 0);
    for (int k = 1; k <= 3; k++) begin
      toggle_at(1000); settle(30);
      chk("t1_vld_cnt", vld_cnt, k);
    end
    chk("t1_idx", idx_o, 3);
    chk("t1_locked", locked, 1);
    chk("t1_period", period_o, 1000);
    chk("t1_latency", 64'(vld_at - t_tog), 7);
    chk("t1_no_err", err_cnt, 0);

    // table extremes
    toggle_at(125); settle(30);
    chk("t2_idx0", idx_o, 0);
    chk("t2_lat0", 64'(vld_at - t_tog), 4);
    chk("t2_period125", period_o, 125);
    toggle_at(30000); settle(30);
    chk("t2_idx15", idx_o, 15);
    chk("t2_lat15", 64'(vld_at - t_tog), 19);
    chk("t2_vld_cnt", vld_cnt, 5);

    // window edge inside / outside
    toggle_at(1060); settle(30);
    chk("t3_idx_1060", idx_o, 3);
    chk("t3_period_1060", period_o, 1060);
    toggle_at(1100); settle(30);
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_err_lat", 64'(err_at - t_tog), 19);
    chk("t3_locked", locked, 0);
    chk("t3_period_1100", period_o, 1100);
    chk("t3_idx_kept", idx_o, 3);
    chk("t3_vld_cnt", vld_cnt, 6);

    // timeout while locked, then an edge that only restarts timing
    toggle_at(1000); settle(30);
    chk("t4_relock", locked, 1);
    settle(31870);
    chk("t4_tmo_err_cnt", err_cnt, 2);
    chk("t4_tmo_lat", 64'(err_at - t_tog), 31879);
    chk("t4_tmo_locked", locked, 0);
    toggle_at(31900); settle(40);
    chk("t4_restart_no_vld", vld_cnt, 7);
    chk("t4_restart_no_err", err_cnt, 2);

    // abort: two toggles 5 clk apart
    toggle_at(1000);
    toggle_at(5);
    toggle_at(5);
    settle(40);
    chk("t5_vld_cnt", vld_cnt, 8);
    chk("t5_err_cnt", err_cnt, 4);
    chk("t5_err_lat", 64'(err_at - t_tog), 19);
    chk("t5_period", period_o, 5);
    chk("t5_locked", locked, 0);
    chk("t5_idx", idx_o, 3);

    // asynchronous reset during a search
    toggle_at(1000); settle(30);
    chk("t6_locked_pre", locked, 1);
    toggle_at(15000); settle(10);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_idx", idx_o, 0);
    chk("t6_rst_period", period_o, 0);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_vld", idx_valid, 0);
    chk("t6_rst_err", err, 0);
    blink_in = 1'b0;
    settle(3);
    rst_n = 1'b1;
    settle(40);
    chk("t6_discard_vld", vld_cnt, 9);
    chk("t6_discard_err", err_cnt, 4);

    // confirm behaviour (pulse on the first or second equal match)
    t_tog = cyc;
    toggle_at(20); settle(30);
    toggle_at(1000); settle(30);
`ifdef BLINK_DEC_CONFIRM_EN
    chk("t7_first_interval", vld_cnt, 9);
`else
    chk("t7_first_interval", vld_cnt, 10);
`endif
    toggle_at(1000); settle(30);
`ifdef BLINK_DEC_CONFIRM_EN
    chk("t7_second_interval", vld_cnt, 10);
`else
    chk("t7_second_interval", vld_cnt, 11);
`endif
    chk("t7_idx", idx_o, 3);
    chk("t7_locked", locked, 1);
    chk("t7_err_cnt", err_cnt, 4);
    chk("vld_err_exclusive", both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
